debounce_multi: RTL and testbench

//   N-channel push-button conditioner: per-channel synchroniser, saturating up/down

---
 rtl/debounce_multi_if.sv | 30 +++
 rtl/debounce_multi.sv | 171 +++++++++++++++++
 tb/tb_debounce_multi.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/debounce_multi_if.sv
// Button-conditioner bus: raw button inputs plus the debounced level and the
// press/release strobes.
//   btn           raw asynchronous button inputs, 1 = pressed
//   level         debounced button state
//   press_pulse   1-cycle strobe on debounced press (and auto-repeats)
//   release_pulse 1-cycle strobe on debounced release
// master: the side that owns the buttons and consumes the strobes.
// slave : the debouncer itself.
interface debounce_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] btn;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] press_pulse;
  logic [CHANNELS-1:0] release_pulse;

  modport master (
    output btn,
    input  level,
    input  press_pulse,
    input  release_pulse
  );

  modport slave (
    input  btn,
    output level,
    output press_pulse,
    output release_pulse
  );
endinterface

// File: rtl/debounce_multi.sv
// N-channel push-button conditioner. Each channel has a synchroniser, a
// saturating up/down integrator, a hysteretic level register and registered
// one-cycle press/release strobes.
//
// Ports
//   clk  in  system clock, rising edge
//   rst  in  asynchronous reset, active high
//   bus  debounce_multi_if.slave (btn in; level, press_pulse, release_pulse out)
//
// Optional feature: define DEBOUNCE_REPEAT_EN to add a per-channel auto-repeat
// timer. While a button stays debounced-pressed, an extra press_pulse is issued
// HOLD_CYCLES cycles after the edge pulse and then every REPEAT_CYCLES cycles.
// Without the macro, press_pulse fires only on debounced edges and the two
// repeat parameters are ignored.
//
// Level state per channel:
//   state        | meaning
//   ST_RELEASED  | level = 0, waiting for cnt >= ON_THRESH
//   ST_PRESSED   | level = 1, waiting for cnt <= OFF_THRESH
module debounce_multi #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 21,
  parameter int ON_THRESH     = 1000000,
  parameter int OFF_THRESH    = 500000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic          clk,
  input  logic          rst,
  debounce_multi_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ON_T    = CNT_W'(ON_THRESH);
  localparam logic [CNT_W-1:0] OFF_T   = CNT_W'(OFF_THRESH);

  if (CHANNELS < 1) begin : g_err_channels
    $error("debounce_multi: CHANNELS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_err_sync
    $error("debounce_multi: SYNC_STAGES must be >= 2");
  end
  if (OFF_THRESH < 0 || OFF_THRESH >= ON_THRESH) begin : g_err_thresh
    $error("debounce_multi: need 0 <= OFF_THRESH < ON_THRESH");
  end
  if (longint'(ON_THRESH) > ((longint'(1) << CNT_W) - 1)) begin : g_err_on_max
    $error("debounce_multi: ON_THRESH exceeds integrator range");
  end
  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_err_repeat
    $error("debounce_multi: HOLD_CYCLES and REPEAT_CYCLES must be >= 1");
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  // Down-counter reload values: the pulse fires on the cycle after the count
  // reaches zero, so load one less than the desired spacing.
  localparam logic [RPT_W-1:0] HOLD_LOAD = RPT_W'(HOLD_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_LOAD  = RPT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } lvl_state_e;

  logic [CHANNELS-1:0] level_v;
  logic [CHANNELS-1:0] press_v;
  logic [CHANNELS-1:0] release_v;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt_q, cnt_nxt;
    lvl_state_e             state_q, state_nxt;
    logic                   edge_press_nxt;
    logic                   rel_nxt;
    logic                   press_q, rel_q;
    logic                   rpt_fire;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q  <= '0;
        cnt_q   <= '0;
        state_q <= ST_RELEASED;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.btn[i]};
        cnt_q   <= cnt_nxt;
        state_q <= state_nxt;
        press_q <= edge_press_nxt | rpt_fire;
        rel_q   <= rel_nxt;
      end
    end

    always_comb begin
      cnt_nxt        = cnt_q;
      state_nxt      = state_q;
      edge_press_nxt = 1'b0;
      rel_nxt        = 1'b0;

      if (s && cnt_q != CNT_MAX) begin
        cnt_nxt = cnt_q + 1'b1;
      end else if (!s && cnt_q != '0) begin
        cnt_nxt = cnt_q - 1'b1;
      end

      // Thresholds compare the registered count, giving one cycle of latency
      // after the integrator crosses.
      case (state_q)
        ST_RELEASED: begin
          if (cnt_q >= ON_T) begin
            state_nxt      = ST_PRESSED;
            edge_press_nxt = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (cnt_q <= OFF_T) begin
            state_nxt = ST_RELEASED;
            rel_nxt   = 1'b1;
          end
        end
        default: state_nxt = ST_RELEASED;
      endcase
    end

`ifdef DEBOUNCE_REPEAT_EN
    logic [RPT_W-1:0] rpt_q, rpt_nxt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rpt_q <= '0;
      end else begin
        rpt_q <= rpt_nxt;
      end
    end

    // Gating on state_nxt drops a repeat that would land in the release cycle,
    // so press and release strobes never coincide.
    always_comb begin
      rpt_nxt  = rpt_q;
      rpt_fire = 1'b0;
      if (state_nxt != ST_PRESSED) begin
        rpt_nxt = '0;
      end else if (state_q == ST_RELEASED) begin
        rpt_nxt = HOLD_LOAD;
      end else if (rpt_q == '0) begin
        rpt_fire = 1'b1;
        rpt_nxt  = RPT_LOAD;
      end else begin
        rpt_nxt = rpt_q - 1'b1;
      end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign level_v[i]   = (state_q == ST_PRESSED);
    assign press_v[i]   = press_q;
    assign release_v[i] = rel_q;
  end

  assign bus.level         = level_v;
  assign bus.press_pulse   = press_v;
  assign bus.release_pulse = release_v;

endmodule

// File: tb/tb_debounce_multi.sv
module tb_debounce_multi;

  localparam int CH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  debounce_multi_if #(.CHANNELS(CH)) bus ();

  debounce_multi #(
    .CHANNELS      (CH),
    .SYNC_STAGES   (2),
    .CNT_W         (4),
    .ON_THRESH     (8),
    .OFF_THRESH    (3),
    .HOLD_CYCLES   (20),
    .REPEAT_CYCLES (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected press_pulse[0] in the repeat run, n = edges after btn rose.
  // Edge press lands at n=11; repeats at +20 then every +5 while level holds.
  function automatic logic exp_rep_press(input int n);
    int d;
    d = n - 11;
`ifdef DEBOUNCE_REPEAT_EN
    return (d == 0) || (d >= 20 && d <= 45 && ((d - 20) % 5) == 0);
`else
    return (d == 0);
`endif
  endfunction

  logic any_evt;

  initial begin
    bus.btn = '0;
    tick(3);
    check_val("rst_level",   32'(bus.level),         32'h0);
    check_val("rst_press",   32'(bus.press_pulse),   32'h0);
    check_val("rst_release", 32'(bus.release_pulse), 32'h0);
    rst = 1'b0;
    tick(5);
    check_val("post_rst_quiet", 32'(bus.level | bus.press_pulse | bus.release_pulse), 32'h0);

    // Clean press on channel 0: level and strobe at edge 11.
    bus.btn[0] = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      tick(1);
      check_val($sformatf("press_level_n%0d", n), 32'(bus.level[0]),       32'(n >= 11));
      check_val($sformatf("press_pulse_n%0d", n), 32'(bus.press_pulse[0]), 32'(n == 11));
      check_val($sformatf("press_ch1_n%0d", n),
                32'({bus.level[1], bus.press_pulse[1], bus.release_pulse[1], bus.release_pulse[0]}), 32'h0);
    end
    // Hold long enough to saturate; a wrapping counter would drop level here.
    any_evt = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick(1);
      any_evt |= ~bus.level[0] | bus.press_pulse[0] | bus.release_pulse[0];
    end
    check_val("sat_hold_stable", 32'(any_evt), 32'h0);

    // Clean release from cnt=15: level falls and strobe at edge 15.
    bus.btn[0] = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick(1);
      check_val($sformatf("rel_level_n%0d", n), 32'(bus.level[0]),         32'(n < 15));
      check_val($sformatf("rel_pulse_n%0d", n), 32'(bus.release_pulse[0]), 32'(n == 15));
      check_val($sformatf("rel_press_n%0d", n), 32'(bus.press_pulse[0]),   32'h0);
    end
    any_evt = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick(1);
      any_evt |= bus.level[0] | bus.press_pulse[0] | bus.release_pulse[0];
    end
    check_val("rel_bottom_quiet", 32'(any_evt), 32'h0);

    // Bounce: toggle every cycle from cnt=0; integrator never exceeds 1.
    any_evt = 1'b0;
    for (int n = 0; n < 100; n++) begin
      bus.btn[0] = ~bus.btn[0];
      tick(1);
      any_evt |= bus.level[0] | bus.press_pulse[0] | bus.release_pulse[0];
    end
    check_val("bounce_quiet", 32'(any_evt), 32'h0);
    bus.btn[0] = 1'b0;
    tick(5);

    // Hysteresis: from cnt=15, go low 11 edges (cnt bottoms at 4), then high.
    bus.btn[0] = 1'b1;
    tick(30);
    check_val("hyst_level_set", 32'(bus.level[0]), 32'h1);
    bus.btn[0] = 1'b0;
    tick(11);
    bus.btn[0] = 1'b1;
    any_evt = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tick(1);
      any_evt |= ~bus.level[0] | bus.release_pulse[0];
    end
    check_val("hyst_held", 32'(any_evt), 32'h0);
    bus.btn[0] = 1'b0;
    tick(25);
    check_val("hyst_final_release", 32'(bus.level[0]), 32'h0);

    // Both channels simultaneously, then async reset mid-operation.
    bus.btn = 2'b11;
    for (int n = 1; n <= 12; n++) begin
      tick(1);
      check_val($sformatf("dual_press_n%0d", n), 32'(bus.press_pulse), (n == 11) ? 32'h3 : 32'h0);
    end
    tick(5);
    check_val("dual_level", 32'(bus.level), 32'h3);
    #3 rst = 1'b1;
    #1;
    check_val("async_rst_level",   32'(bus.level),         32'h0);
    check_val("async_rst_press",   32'(bus.press_pulse),   32'h0);
    check_val("async_rst_release", 32'(bus.release_pulse), 32'h0);
    bus.btn = 2'b00;
    tick(2);
    rst = 1'b0;
    any_evt = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick(1);
      any_evt |= |(bus.level | bus.press_pulse | bus.release_pulse);
    end
    check_val("post_async_rst_quiet", 32'(any_evt), 32'h0);

    // Long press: btn high for 44 edges, level falls at edge 59 (press+48).
    bus.btn[0] = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      tick(1);
      if (n == 44) bus.btn[0] = 1'b0;
      check_val($sformatf("rep_press_n%0d", n), 32'(bus.press_pulse[0]), 32'(exp_rep_press(n)));
      check_val($sformatf("rep_rel_n%0d", n),   32'(bus.release_pulse[0]), 32'(n == 59));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
